mips_mc_control: RTL and testbench

Multicycle MIPS controller: the producer side of the ALU's 4-bit control interface. Sequences fetch, decode, execute, memory and write-back steps per instruction, and drives datapath mux selects and write enables. Emits the ALU operation code each cycle and consumes the ALU's zero and overflow flags. Sits between the instruction register and the multicycle datapath containing the ALU.

---
 rtl/mips_pkg.sv | 70 +++++++
 rtl/alu_decoder.sv | 32 +++
 rtl/mips_mc_control.sv | 197 +++++++++++++++++++
 tb/tb_mips_mc_control.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: ALU codes, opcodes, functs, states, mux selects.
// The EXCEPT state only exists when OVFL_TRAP_EN is defined.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic       SRC_A_PC     = 1'b0;
    localparam logic       SRC_A_REG    = 1'b1;
    localparam logic [1:0] SRC_B_REG    = 2'd0;
    localparam logic [1:0] SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] SRC_B_IMM    = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_EXC    = 2'd3;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
`ifdef OVFL_TRAP_EN
        , S_EXCEPT
`endif
    } state_e;

    // Only signed add/sub can trap; addu/subu wrap silently.
    function automatic logic is_trap_funct(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from {alu_op, funct}; valid drops on an unknown R-type funct.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_e     alu_op,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_control,
    output logic        valid
);

    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_control = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_control = ALU_SUB;
                    FN_AND:          alu_control = ALU_AND;
                    FN_OR:           alu_control = ALU_OR;
                    FN_NOR:          alu_control = ALU_NOR;
                    FN_SLT:          alu_control = ALU_SLT;
                    default:         valid       = 1'b0;
                endcase
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM driving datapath selects/enables and the ALU control code.
// Define OVFL_TRAP_EN to trap signed add/sub/addi overflow through the EXCEPT state.
module mips_mc_control
    import mips_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    input  logic        i_zf,
    input  logic        i_ovfl,
    input  logic        i_mem_ready,
    output logic [3:0]  o_alu_control,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_pc_src,
    output logic        o_pc_en,
    output logic        o_iord,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_ir_write,
    output logic        o_reg_dst,
    output logic        o_mem_to_reg,
    output logic        o_reg_write,
    output logic        o_illegal,
    output logic        o_exception
);

    state_e     state, state_nxt;
    alu_op_e    alu_op;
    logic [3:0] dec_alu_control;
    logic       dec_valid;
    logic       alu_zero, pc_write, branch, exception;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (i_funct),
        .alu_control (dec_alu_control),
        .valid       (dec_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_RESET;
        else          state <= state_nxt;
    end

`ifdef OVFL_TRAP_EN
    // Overflow is judged on the execute cycle; the write-back cycle acts on the registered copy.
    logic ovfl_q, trap;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                  ovfl_q <= 1'b0;
        else if (state == S_EXEC || state == S_ADDIEX) ovfl_q <= i_ovfl;
    end

    assign trap = ovfl_q && ((state == S_ALUWB && is_trap_funct(i_funct)) || state == S_ADDIWB);
`else
    logic unused_ovfl;
    assign unused_ovfl = i_ovfl;
`endif

    always_comb begin
        state_nxt    = state;
        alu_op       = ALUOP_ADD;
        alu_zero     = 1'b0;
        o_alu_src_a  = SRC_A_PC;
        o_alu_src_b  = SRC_B_REG;
        o_pc_src     = PC_SRC_ALU;
        pc_write     = 1'b0;
        branch       = 1'b0;
        o_iord       = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_write  = 1'b0;
        o_illegal    = 1'b0;
        exception    = 1'b0;
        case (state)
            S_RESET: begin
                alu_zero  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRC_B_FOUR;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    pc_write   = 1'b1;
                    state_nxt  = S_DECODE;
                end
            end
            S_DECODE: begin
                o_alu_src_b = SRC_B_IMM_SH;
                case (i_opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        o_illegal = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                o_alu_src_a = SRC_A_REG;
                o_alu_src_b = SRC_B_IMM;
                state_nxt   = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                o_iord     = 1'b1;
                o_mem_read = 1'b1;
                if (i_mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MEMWR: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
                if (i_mem_ready) state_nxt = S_FETCH;
            end
            S_EXEC: begin
                o_alu_src_a = SRC_A_REG;
                alu_op      = ALUOP_FUNCT;
                if (!dec_valid) begin
                    o_illegal = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_ALUWB;
                end
            end
            S_ALUWB: begin
                o_alu_src_a = SRC_A_REG;
                alu_op      = ALUOP_FUNCT;
                o_reg_dst   = 1'b1;
                o_reg_write = 1'b1;
                state_nxt   = S_FETCH;
`ifdef OVFL_TRAP_EN
                if (trap) begin
                    o_reg_write = 1'b0;
                    state_nxt   = S_EXCEPT;
                end
`endif
            end
            S_BRANCH: begin
                o_alu_src_a = SRC_A_REG;
                alu_op      = ALUOP_SUB;
                o_pc_src    = PC_SRC_ALUOUT;
                branch      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_ADDIEX: begin
                o_alu_src_a = SRC_A_REG;
                o_alu_src_b = SRC_B_IMM;
                state_nxt   = S_ADDIWB;
            end
            S_ADDIWB: begin
                o_alu_src_a = SRC_A_REG;
                o_alu_src_b = SRC_B_IMM;
                o_reg_write = 1'b1;
                state_nxt   = S_FETCH;
`ifdef OVFL_TRAP_EN
                if (trap) begin
                    o_reg_write = 1'b0;
                    state_nxt   = S_EXCEPT;
                end
`endif
            end
            S_JUMP: begin
                o_pc_src  = PC_SRC_JUMP;
                pc_write  = 1'b1;
                state_nxt = S_FETCH;
            end
`ifdef OVFL_TRAP_EN
            S_EXCEPT: begin
                o_pc_src  = PC_SRC_EXC;
                pc_write  = 1'b1;
                exception = 1'b1;
                state_nxt = S_FETCH;
            end
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // The reset state drives an all-zero ALU code rather than the ADD default.
    assign o_alu_control = alu_zero ? 4'b0000 : dec_alu_control;
    assign o_pc_en       = pc_write | (branch & i_zf);
    assign o_exception   = exception;

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized bench for mips_mc_control against a per-instruction summary model.
module tb_mips_mc_control;

    logic       i_clk, i_rst_n;
    logic [5:0] i_opcode, i_funct;
    logic       i_zf, i_ovfl, i_mem_ready;
    logic [3:0] o_alu_control;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b, o_pc_src;
    logic       o_pc_en, o_iord, o_mem_read, o_mem_write, o_ir_write;
    logic       o_reg_dst, o_mem_to_reg, o_reg_write, o_illegal, o_exception;

    int checks = 0;
    int errors = 0;

`ifdef OVFL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    mips_mc_control dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_funct(i_funct),
        .i_zf(i_zf), .i_ovfl(i_ovfl), .i_mem_ready(i_mem_ready),
        .o_alu_control(o_alu_control), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
        .o_pc_src(o_pc_src), .o_pc_en(o_pc_en), .o_iord(o_iord), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_ir_write(o_ir_write), .o_reg_dst(o_reg_dst),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_illegal(o_illegal),
        .o_exception(o_exception)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [18:0] all_outs;
    assign all_outs = {o_alu_control, o_alu_src_a, o_alu_src_b, o_pc_src, o_pc_en, o_iord,
                       o_mem_read, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
                       o_reg_write, o_illegal, o_exception};

    // One instruction summarised: cycle count, event counts and where key events happened.
    typedef struct packed {
        logic [7:0] cycles;
        logic [3:0] n_rw;
        logic [7:0] rw_last;
        logic       rw_dst;
        logic       rw_m2r;
        logic [7:0] n_rd;
        logic [7:0] n_wr;
        logic [3:0] n_pc;
        logic [3:0] n_ir;
        logic [3:0] n_ill;
        logic [3:0] n_exc;
        logic [3:0] alu_ex;
        logic [1:0] exc_pc_src;
        logic       timeout;
    } obs_t;

    logic [5:0] op_pool [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h05};
    logic [5:0] fn_pool [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A,
                                 6'h00, 6'h26, 6'h3F};

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20, 6'h21: return 4'b0010;
            6'h22, 6'h23: return 4'b0110;
            6'h24:        return 4'b0000;
            6'h25:        return 4'b0001;
            6'h27:        return 4'b1100;
            6'h2A:        return 4'b0111;
            default:      return 4'b0010;
        endcase
    endfunction

    function automatic bit fn_ok(input logic [5:0] fn);
        return fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
    endfunction

    // Expected summary from the instruction-level rules: base latency, waits, traps, events.
    function automatic obs_t exp_of(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                                    input logic ov, input int fw, input int mw);
        obs_t e = '0;
        bit trap = 1'b0;
        bit rw = 1'b0;
        int base;
        e.n_ir = 4'd1;
        e.n_pc = 4'd1;
        e.n_rd = 8'(fw + 1);
        case (op)
            6'h00: begin
                e.alu_ex = alu_of(fn);
                if (!fn_ok(fn)) begin
                    base = 3;
                    e.n_ill = 4'd1;
                end else begin
                    trap = TRAP_EN && ov && (fn == 6'h20 || fn == 6'h22);
                    base = trap ? 5 : 4;
                    rw = !trap;
                    e.rw_dst = !trap;
                end
            end
            6'h08: begin
                e.alu_ex = 4'b0010;
                trap = TRAP_EN && ov;
                base = trap ? 5 : 4;
                rw = !trap;
            end
            6'h23: begin
                e.alu_ex = 4'b0010;
                base = 5 + mw;
                rw = 1'b1;
                e.rw_m2r = 1'b1;
                e.n_rd = 8'(fw + 1 + mw + 1);
            end
            6'h2B: begin
                e.alu_ex = 4'b0010;
                base = 4 + mw;
                e.n_wr = 8'(mw + 1);
            end
            6'h04: begin
                e.alu_ex = 4'b0110;
                base = 3;
                e.n_pc = e.n_pc + 4'(zf);
            end
            6'h02: begin
                e.alu_ex = 4'b0010;
                base = 3;
                e.n_pc = 4'd2;
            end
            default: begin
                base = 2;
                e.n_ill = 4'd1;
            end
        endcase
        if (trap) begin
            e.n_exc = 4'd1;
            e.n_pc = e.n_pc + 4'd1;
            e.exc_pc_src = 2'd3;
        end
        e.cycles = 8'(base + fw);
        if (rw) begin
            e.n_rw = 4'd1;
            e.rw_last = e.cycles;
        end
        return e;
    endfunction

    // Enter just after a falling edge with the DUT in FETCH; leave the same way.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                             input logic ov, input int fw, input int mw, output obs_t o);
        int c = 0;
        int fc = 0;
        int mc = 0;
        bit done = 1'b0;
        o = '0;
        i_opcode = op;
        i_funct = fn;
        i_zf = zf;
        i_ovfl = ov;
        while (!done) begin
            c++;
            if (o_mem_read && !o_iord) begin
                i_mem_ready = (fc >= fw);
                fc++;
            end else if (o_iord) begin
                i_mem_ready = (mc >= mw);
                mc++;
            end else begin
                i_mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (o_reg_write) begin
                o.n_rw = o.n_rw + 4'd1;
                o.rw_last = 8'(c);
                o.rw_dst = o_reg_dst;
                o.rw_m2r = o_mem_to_reg;
            end
            if (o_mem_read)  o.n_rd = o.n_rd + 8'd1;
            if (o_mem_write) o.n_wr = o.n_wr + 8'd1;
            if (o_pc_en)     o.n_pc = o.n_pc + 4'd1;
            if (o_ir_write)  o.n_ir = o.n_ir + 4'd1;
            if (o_illegal)   o.n_ill = o.n_ill + 4'd1;
            if (o_exception) begin
                o.n_exc = o.n_exc + 4'd1;
                o.exc_pc_src = o_pc_src;
            end
            if (c == fw + 3) o.alu_ex = o_alu_control;
            @(negedge i_clk);
            if (o_mem_read && !o_iord && o.n_ir != 0) done = 1'b1;
            if (c >= 40) begin
                o.timeout = 1'b1;
                done = 1'b1;
            end
        end
        o.cycles = 8'(c);
    endtask

    task automatic release_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_opcode = 6'h00;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (all_outs !== 19'd0) begin
            errors++;
            $display("FAIL reset_outs got %h exp 0", all_outs);
        end
        release_reset();
        checks++;
        if (o_mem_read !== 1'b1 || o_iord !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch mem_read %b iord %b exp 1 0", o_mem_read, o_iord);
        end
        checks++;
        if (o_alu_control !== 4'b0010) begin
            errors++;
            $display("FAIL reset_alu got %b exp 0010", o_alu_control);
        end
        @(negedge i_clk);
    endtask

    task automatic test_rtype_sub();
        obs_t o, e;
        run_instr(6'h00, 6'h22, 1'b0, 1'b0, 0, 0, o);
        e = exp_of(6'h00, 6'h22, 1'b0, 1'b0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL rtype_sub got %h exp %h", o, e);
        end
        checks++;
        if (o.alu_ex !== 4'b0110 || o.rw_last !== 8'd4 || o.rw_dst !== 1'b1) begin
            errors++;
            $display("FAIL rtype_sub_exec alu %b rw_cycle %0d dst %b exp 0110 4 1",
                     o.alu_ex, o.rw_last, o.rw_dst);
        end
    endtask

    task automatic test_lw_wait();
        obs_t o, e;
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 3, o);
        e = exp_of(6'h23, 6'h00, 1'b0, 1'b0, 0, 3);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL lw_wait got %h exp %h", o, e);
        end
        checks++;
        if (o.cycles !== 8'd8 || o.rw_last !== 8'd8) begin
            errors++;
            $display("FAIL lw_wait_cycles cycles %0d rw_cycle %0d exp 8 8", o.cycles, o.rw_last);
        end
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 2, 2, o);
        e = exp_of(6'h2B, 6'h00, 1'b0, 1'b0, 2, 2);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL sw_wait got %h exp %h", o, e);
        end
    endtask

    task automatic test_beq();
        obs_t o, e;
        for (int z = 1; z >= 0; z--) begin
            run_instr(6'h04, 6'h00, 1'(z), 1'b0, 0, 0, o);
            e = exp_of(6'h04, 6'h00, 1'(z), 1'b0, 0, 0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL beq_zf%0d got %h exp %h", z, o, e);
            end
        end
    endtask

    task automatic test_illegal();
        obs_t o, e;
        run_instr(6'h3F, 6'h20, 1'b1, 1'b0, 1, 0, o);
        e = exp_of(6'h3F, 6'h20, 1'b1, 1'b0, 1, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL illegal_op got %h exp %h", o, e);
        end
        run_instr(6'h00, 6'h26, 1'b0, 1'b0, 0, 0, o);
        e = exp_of(6'h00, 6'h26, 1'b0, 1'b0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL illegal_funct got %h exp %h", o, e);
        end
    endtask

    task automatic test_ovfl();
        obs_t o, e;
        logic [5:0] fns [3] = '{6'h20, 6'h21, 6'h22};
        for (int k = 0; k < 3; k++) begin
            run_instr(6'h00, fns[k], 1'b0, 1'b1, 0, 0, o);
            e = exp_of(6'h00, fns[k], 1'b0, 1'b1, 0, 0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ovfl_funct%h got %h exp %h", fns[k], o, e);
            end
        end
        run_instr(6'h08, 6'h00, 1'b0, 1'b1, 0, 0, o);
        e = exp_of(6'h08, 6'h00, 1'b0, 1'b1, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL ovfl_addi got %h exp %h", o, e);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            logic zf, ov;
            int fw, mw;
            op = op_pool[$urandom_range(0, 7)];
            fn = fn_pool[$urandom_range(0, 10)];
            zf = 1'($urandom_range(0, 1));
            ov = 1'($urandom_range(0, 1));
            fw = int'($urandom_range(0, 2));
            mw = int'($urandom_range(0, 2));
            run_instr(op, fn, zf, ov, fw, mw, o);
            e = exp_of(op, fn, zf, ov, fw, mw);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rand%0d op %h fn %h got %h exp %h", n, op, fn, o, e);
            end
        end
    endtask

    task automatic test_reset_abort();
        obs_t o, e;
        i_opcode = 6'h2B;
        i_mem_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        @(negedge i_clk);
        #1;
        checks++;
        if (o_mem_write !== 1'b1 || o_iord !== 1'b1) begin
            errors++;
            $display("FAIL abort_memwr mem_write %b iord %b exp 1 1", o_mem_write, o_iord);
        end
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs !== 19'd0) begin
            errors++;
            $display("FAIL abort_outs got %h exp 0", all_outs);
        end
        i_mem_ready = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if (all_outs !== 19'd0) begin
            errors++;
            $display("FAIL abort_hold got %h exp 0", all_outs);
        end
        i_mem_ready = 1'b0;
        release_reset();
        checks++;
        if (o_mem_read !== 1'b1 || o_iord !== 1'b0 || o_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL abort_fetch rd %b iord %b wr %b exp 1 0 0",
                     o_mem_read, o_iord, o_mem_write);
        end
        @(negedge i_clk);
        run_instr(6'h02, 6'h00, 1'b0, 1'b0, 1, 0, o);
        e = exp_of(6'h02, 6'h00, 1'b0, 1'b0, 1, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_recover got %h exp %h", o, e);
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_opcode = 6'h00;
        i_funct = 6'h00;
        i_zf = 1'b0;
        i_ovfl = 1'b0;
        i_mem_ready = 1'b0;
        test_reset();
        test_rtype_sub();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_ovfl();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
